// File: rtl/pcie_link_mon_pkg.sv
// Shared LTSSM encodings, FSM state type and test-bus layout for pcie_link_monitor.
package pcie_link_mon_pkg;

   localparam logic [4:0] L0         = 5'b01111;
   localparam logic [4:0] POLL_COMPL = 5'b00011;
   localparam logic [4:0] REC_LOCK   = 5'b01100;
   localparam logic [4:0] REC_CFG    = 5'b01101;
   localparam logic [4:0] REC_IDLE   = 5'b01110;

   localparam int unsigned LANE_OFS = 25;

   typedef enum logic [1:0] {
      StDown,
      StTrain,
      StUp,
      StRecov
   } link_st_t;

   function automatic logic is_recovery(logic [4:0] st);
      return (st == REC_LOCK) || (st == REC_CFG) || (st == REC_IDLE);
   endfunction

endpackage

// File: rtl/pcie_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats a same-cycle increment.
module pcie_sat_counter #(
   parameter int unsigned W = 16
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         inc_i,
   input  logic         clr_i,
   output logic [W-1:0] count_o
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && (cnt_q != '1)) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign count_o = cnt_q;

endmodule

// File: rtl/pcie_link_monitor.sv
// PCIe hard-IP link monitor: LTSSM decode, debounced link_up, LEDs and heartbeat.
// Define PCIE_LINK_MON_STATS_EN to build ltssm_change and the link-health counters.
module pcie_link_monitor
   import pcie_link_mon_pkg::*;
#(
   parameter int unsigned NUM_LANES    = 1,
   parameter int unsigned DEBOUNCE_CYC = 1024,
   parameter int unsigned ALIVE_BIT    = 24,
   parameter int unsigned CNT_W        = 16
) (
   input  logic                 clk125,
   input  logic                 rst,
   input  logic [63:0]          test_out_icm,
   input  logic                 cnt_clr,
   output logic [4:0]           ltssm_q,
   output logic                 link_up,
   output logic                 l0_led,
   output logic                 comp_led,
   output logic                 alive_led,
   output logic [NUM_LANES-1:0] lane_led,
   output logic                 ltssm_change,
   output logic [CNT_W-1:0]     link_down_cnt,
   output logic [CNT_W-1:0]     recovery_cnt
);

   localparam int unsigned DbW = $clog2(DEBOUNCE_CYC + 1);

   logic [NUM_LANES-1:0] lanes_q;
   logic [ALIVE_BIT:0]   alive_q;
   logic [DbW-1:0]       db_cnt_q;
   link_st_t             state_q;

   logic is_l0, is_rec, link_down_ev, rec_ev;

   assign is_l0  = (ltssm_q == L0);
   assign is_rec = is_recovery(ltssm_q);

   always_ff @(posedge clk125) begin
      if (rst) begin
         ltssm_q  <= '0;
         lanes_q  <= '0;
         l0_led   <= 1'b1;
         comp_led <= 1'b1;
         lane_led <= '1;
         alive_q  <= '0;
      end else begin
         ltssm_q  <= test_out_icm[4:0];
         lanes_q  <= test_out_icm[LANE_OFS +: NUM_LANES];
         l0_led   <= ~is_l0;
         comp_led <= ~(ltssm_q == POLL_COMPL);
         lane_led <= ~lanes_q;
         alive_q  <= alive_q + (ALIVE_BIT + 1)'(1);
      end
   end

   assign alive_led = alive_q[ALIVE_BIT];

   // A drop during TRAIN is a failed bring-up, not a link-down event.
   always_ff @(posedge clk125) begin
      if (rst) begin
         state_q  <= StDown;
         db_cnt_q <= '0;
      end else begin
         case (state_q)
            StDown: begin
               if (is_l0) begin
                  state_q  <= StTrain;
                  db_cnt_q <= DbW'(1);
               end
            end
            StTrain: begin
               if (!is_l0) begin
                  state_q <= StDown;
               end else if (db_cnt_q == DbW'(DEBOUNCE_CYC)) begin
                  state_q <= StUp;
               end else begin
                  db_cnt_q <= db_cnt_q + DbW'(1);
               end
            end
            StUp: begin
               if (is_rec) begin
                  state_q <= StRecov;
               end else if (!is_l0) begin
                  state_q <= StDown;
               end
            end
            StRecov: begin
               if (is_l0) begin
                  state_q <= StUp;
               end else if (!is_rec) begin
                  state_q <= StDown;
               end
            end
            default: state_q <= StDown;
         endcase
      end
   end

   assign link_up      = (state_q == StUp) || (state_q == StRecov);
   assign link_down_ev = link_up && !is_l0 && !is_rec;
   assign rec_ev       = (state_q == StUp) && is_rec;

`ifdef PCIE_LINK_MON_STATS_EN
   logic change_q;

   always_ff @(posedge clk125) begin
      if (rst) begin
         change_q <= 1'b0;
      end else begin
         change_q <= (test_out_icm[4:0] != ltssm_q);
      end
   end

   assign ltssm_change = change_q;

   pcie_sat_counter #(
      .W (CNT_W)
   ) u_down_cnt (
      .clk_i   (clk125),
      .rst_i   (rst),
      .inc_i   (link_down_ev),
      .clr_i   (cnt_clr),
      .count_o (link_down_cnt)
   );

   pcie_sat_counter #(
      .W (CNT_W)
   ) u_rec_cnt (
      .clk_i   (clk125),
      .rst_i   (rst),
      .inc_i   (rec_ev),
      .clr_i   (cnt_clr),
      .count_o (recovery_cnt)
   );
`else
   logic unused_stats;

   assign ltssm_change  = 1'b0;
   assign link_down_cnt = '0;
   assign recovery_cnt  = '0;
   assign unused_stats  = ^{cnt_clr, link_down_ev, rec_ev};
`endif

   logic unused_test_out;
   assign unused_test_out = ^{test_out_icm[63:LANE_OFS+NUM_LANES], test_out_icm[LANE_OFS-1:5]};

endmodule

// File: tb/tb_pcie_link_monitor.sv
// Scoreboard bench for pcie_link_monitor: timed expectations queued at drive time, checked per edge.
module tb_pcie_link_monitor;

   localparam int unsigned NumLanes = 4;
   localparam int unsigned DebCyc   = 8;
   localparam int unsigned AliveBit = 3;
   localparam int unsigned CntW     = 2;

`ifdef PCIE_LINK_MON_STATS_EN
   localparam int StatsEn = 1;
`else
   localparam int StatsEn = 0;
`endif

   localparam logic [4:0] StL0    = 5'b01111;
   localparam logic [4:0] StCompl = 5'b00011;
   localparam logic [4:0] StRec   = 5'b01100;
   localparam logic [4:0] StDet   = 5'b00000;
   localparam logic [4:0] StGlit  = 5'b00010;

   logic                clk125 = 1'b0;
   logic                rst = 1'b1;
   logic [63:0]         test_out_icm = '0;
   logic                cnt_clr = 1'b0;
   logic [4:0]          ltssm_q;
   logic                link_up, l0_led, comp_led, alive_led, ltssm_change;
   logic [NumLanes-1:0] lane_led;
   logic [CntW-1:0]     link_down_cnt, recovery_cnt;

   pcie_link_monitor #(
      .NUM_LANES    (NumLanes),
      .DEBOUNCE_CYC (DebCyc),
      .ALIVE_BIT    (AliveBit),
      .CNT_W        (CntW)
   ) dut (
      .clk125        (clk125),
      .rst           (rst),
      .test_out_icm  (test_out_icm),
      .cnt_clr       (cnt_clr),
      .ltssm_q       (ltssm_q),
      .link_up       (link_up),
      .l0_led        (l0_led),
      .comp_led      (comp_led),
      .alive_led     (alive_led),
      .lane_led      (lane_led),
      .ltssm_change  (ltssm_change),
      .link_down_cnt (link_down_cnt),
      .recovery_cnt  (recovery_cnt)
   );

   always #4 clk125 = ~clk125;

   typedef enum int {
      SigLtssm, SigLinkUp, SigL0Led, SigCompLed, SigAlive, SigLaneLed, SigChange, SigDownCnt,
      SigRecCnt
   } sig_e;

   typedef struct {
      int          edge_no;
      sig_e        sig;
      logic [31:0] exp;
      string       tag;
   } sb_item_t;

   sb_item_t sb_q[$];
   int n_tests = 0;
   int n_fail  = 0;
   int edges   = 0;

   task automatic check_eq(string tag, logic [31:0] obs, logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (edge %0d)", tag, obs, exp, edges);
      end
   endtask

   function automatic logic [31:0] get_sig(sig_e s);
      case (s)
         SigLtssm:   return 32'(ltssm_q);
         SigLinkUp:  return 32'(link_up);
         SigL0Led:   return 32'(l0_led);
         SigCompLed: return 32'(comp_led);
         SigAlive:   return 32'(alive_led);
         SigLaneLed: return 32'(lane_led);
         SigChange:  return 32'(ltssm_change);
         SigDownCnt: return 32'(link_down_cnt);
         SigRecCnt:  return 32'(recovery_cnt);
         default:    return 32'hFFFF_FFFF;
      endcase
   endfunction

   // Expect signal s to hold exp right after the dly-th upcoming edge.
   task automatic expect_at(int dly, sig_e s, logic [31:0] exp, string tag);
      sb_item_t it;
      it.edge_no = edges + dly;
      it.sig     = s;
      it.exp     = exp;
      it.tag     = tag;
      sb_q.push_back(it);
   endtask

   task automatic tick();
      @(posedge clk125);
      #1;
      edges++;
      for (int i = sb_q.size() - 1; i >= 0; i--) begin
         if (sb_q[i].edge_no == edges) begin
            check_eq(sb_q[i].tag, get_sig(sb_q[i].sig), sb_q[i].exp);
            sb_q.delete(i);
         end
      end
   endtask

   task automatic ticks(int n);
      repeat (n) tick();
   endtask

   task automatic drive(logic [4:0] st, logic [3:0] lanes);
      test_out_icm        = '0;
      test_out_icm[4:0]   = st;
      test_out_icm[28:25] = lanes;
   endtask

   task automatic check_reset_vals(string pfx);
      check_eq({pfx, "_ltssm"}, 32'(ltssm_q), 0);
      check_eq({pfx, "_link_up"}, 32'(link_up), 0);
      check_eq({pfx, "_l0_led"}, 32'(l0_led), 1);
      check_eq({pfx, "_comp_led"}, 32'(comp_led), 1);
      check_eq({pfx, "_lane_led"}, 32'(lane_led), 32'hF);
      check_eq({pfx, "_alive"}, 32'(alive_led), 0);
      check_eq({pfx, "_change"}, 32'(ltssm_change), 0);
      check_eq({pfx, "_down_cnt"}, 32'(link_down_cnt), 0);
      check_eq({pfx, "_rec_cnt"}, 32'(recovery_cnt), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int guard;

      // Reset held while the bus already shows L0.
      rst = 1'b1;
      drive(StL0, 4'hF);
      repeat (3) begin
         tick();
         check_eq("rst_hold_link_up", 32'(link_up), 0);
      end
      check_reset_vals("rst");

      // Release into L0, then glitch after 5 cycles.
      rst = 1'b0;
      drive(StL0, 4'h0);
      expect_at(1, SigLtssm, 32'(StL0), "l0_ltssm_q");
      expect_at(1, SigChange, StatsEn, "l0_change_pulse");
      expect_at(2, SigChange, 0, "l0_change_clear");
      expect_at(1, SigL0Led, 1, "l0_led_still_dark");
      expect_at(2, SigL0Led, 0, "l0_led_lit");
      expect_at(7, SigAlive, 0, "alive_cnt7");
      expect_at(8, SigAlive, 1, "alive_cnt8");
      expect_at(15, SigAlive, 1, "alive_cnt15");
      expect_at(16, SigAlive, 0, "alive_wrap");
      ticks(5);
      drive(StGlit, 4'h0);
      expect_at(1, SigLtssm, 32'(StGlit), "glitch_ltssm_q");
      expect_at(1, SigChange, StatsEn, "glitch_change");
      expect_at(2, SigL0Led, 1, "glitch_l0_led");
      ticks(1);
      drive(StL0, 4'h0);
      expect_at(1, SigLinkUp, 0, "glitch_link_low");
      expect_at(9, SigLinkUp, 0, "debounce_k8");
      expect_at(10, SigLinkUp, 1, "debounce_k9");
      expect_at(12, SigDownCnt, 0, "glitch_no_drop");
      ticks(12);

      // Recovery excursion then a real drop.
      drive(StRec, 4'h0);
      for (int d = 1; d <= 6; d++) expect_at(d, SigLinkUp, 1, "recov_link_held");
      expect_at(1, SigRecCnt, 0, "recov_cnt_before");
      expect_at(2, SigRecCnt, StatsEn, "recov_cnt_inc");
      expect_at(6, SigRecCnt, StatsEn, "recov_cnt_hold");
      ticks(3);
      drive(StL0, 4'h0);
      ticks(3);
      drive(StDet, 4'h0);
      expect_at(1, SigLinkUp, 1, "drop_link_k1");
      expect_at(2, SigLinkUp, 0, "drop_link_k2");
      expect_at(1, SigDownCnt, 0, "drop_cnt_k1");
      expect_at(2, SigDownCnt, StatsEn, "drop_cnt_k2");
      ticks(2);

      // Four more drops saturate the 2-bit counter at 3.
      for (int n = 2; n <= 5; n++) begin
         drive(StL0, 4'h0);
         expect_at(10, SigLinkUp, 1, "sat_relink");
         ticks(10);
         drive(StDet, 4'h0);
         expect_at(2, SigLinkUp, 0, "sat_drop_link");
         expect_at(2, SigDownCnt, StatsEn * ((n > 3) ? 3 : n), "sat_drop_cnt");
         ticks(2);
      end

      // Sixth drop coincides with the clear.
      drive(StL0, 4'h0);
      ticks(10);
      drive(StDet, 4'h0);
      expect_at(1, SigDownCnt, StatsEn * 3, "clr_pre");
      expect_at(2, SigDownCnt, 0, "clr_wins");
      expect_at(3, SigDownCnt, 0, "clr_stays");
      expect_at(2, SigRecCnt, 0, "clr_rec_cnt");
      ticks(1);
      cnt_clr = 1'b1;
      ticks(1);
      cnt_clr = 1'b0;
      ticks(1);

      // Lanes and compliance LEDs.
      drive(StCompl, 4'b0101);
      expect_at(1, SigLtssm, 32'(StCompl), "compl_ltssm_q");
      expect_at(1, SigCompLed, 1, "compl_led_k1");
      expect_at(2, SigCompLed, 0, "compl_led_k2");
      expect_at(1, SigLaneLed, 32'hF, "lane_led_k1");
      expect_at(2, SigLaneLed, 32'hA, "lane_led_k2");
      expect_at(2, SigLinkUp, 0, "compl_link_down");
      ticks(3);

      // Reset in the middle of TRAIN restarts the debounce from scratch.
      drive(StL0, 4'h0);
      ticks(4);
      rst = 1'b1;
      ticks(1);
      check_reset_vals("rst_train");
      rst = 1'b0;
      expect_at(9, SigLinkUp, 0, "retrain_k8");
      expect_at(10, SigLinkUp, 1, "retrain_k9");
      ticks(12);

      // Reset in the middle of RECOV.
      drive(StRec, 4'h0);
      ticks(3);
      check_eq("recov_before_rst", 32'(link_up), 1);
      rst = 1'b1;
      ticks(1);
      check_reset_vals("rst_recov");
      rst = 1'b0;
      drive(StDet, 4'h0);
      expect_at(1, SigChange, 0, "no_change_after_rst");
      expect_at(3, SigLinkUp, 0, "recov_rst_link_low");
      ticks(3);

      guard = 0;
      while (sb_q.size() > 0 && guard < 50) begin
         tick();
         guard++;
      end
      foreach (sb_q[i]) begin
         n_tests++;
         n_fail++;
         $display("FAIL %s: got no sample, expected %0h at edge %0d", sb_q[i].tag, sb_q[i].exp,
                  sb_q[i].edge_no);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/pcie_link_monitor.md
# pcie_link_monitor

Parametrised PCIe link-status monitor for the Cyclone IV GX hard-IP designs. It decodes the hard IP `test_out` bus: the LTSSM state and the per-lane activity bits. It drives status LEDs, a debounced `link_up` flag, and optional link-health statistics. It sits in the top level on the 125 MHz fixed clock and generalises the single-lane L0 LED logic to 1–8 lanes, with debounce, recovery tracking and counters.

## Interface
- `NUM_LANES`, 1: lane count; legal values are 1, 2, 4, 8.
- `DEBOUNCE_CYC`, 1024: consecutive L0 cycles needed before `link_up` rises; minimum 2.
- `ALIVE_BIT`, 24: bit of the free-running counter that drives `alive_led`.
- `CNT_W`, 16: width of the statistics counters.
- `clk125`  in  1  125 MHz fixed clock; all logic is on this edge.
- `rst`  in  1  synchronous, active-high reset.
- `test_out_icm`  in  64  hard IP test bus. `[4:0]` is the LTSSM state; `[25 +: NUM_LANES]` is lane active.
- `cnt_clr`  in  1  synchronous clear of the statistics counters.
- `ltssm_q`  out  5  registered LTSSM state.
- `link_up`  out  1  debounced link-up flag.
- `l0_led`  out  1  active-low; lit while `ltssm_q` == L0.
- `comp_led`  out  1  active-low; lit while in Polling.Compliance.
- `alive_led`  out  1  heartbeat.
- `lane_led`  out  NUM_LANES  active-low lane-active indicators.
- `ltssm_change`  out  1  one-cycle pulse when `ltssm_q` changes.
- `link_down_cnt`  out  CNT_W  saturating count of link-down events.
- `recovery_cnt`  out  CNT_W  saturating count of Recovery entries from UP.

## Operation
- LTSSM encodings: L0 = 5'b01111; Polling.Compliance = 5'b00011; Recovery = 5'b01100, 5'b01101, 5'b01110.
- Input stage: `ltssm_q` and the lane bits are registered each cycle. All decoding uses the registered values.
- The FSM has four states: DOWN, TRAIN, UP and RECOV.
- From DOWN:
  - If `ltssm_q` == L0, go to TRAIN and load the debounce counter with 1.
- From TRAIN:
  - If `ltssm_q` != L0, go to DOWN. This is not counted as a link-down event.
  - If `ltssm_q` == L0 and the counter == DEBOUNCE_CYC, go to UP.
  - Otherwise, increment the counter.
- From UP:
  - If `ltssm_q` is a Recovery state, go to RECOV and increment `recovery_cnt`.
  - If `ltssm_q` is any other non-L0 state, go to DOWN and increment `link_down_cnt`.
- From RECOV:
  - If `ltssm_q` == L0, go to UP.
  - If `ltssm_q` is a Recovery state, stay in RECOV.
  - Otherwise, go to DOWN and increment `link_down_cnt`.
- `link_up` is 1 when the state is UP or RECOV, decoded from the state register.
- LEDs:
  - `l0_led` = ~(ltssm_q == L0).
  - `comp_led` = ~(ltssm_q == Polling.Compliance).
  - `lane_led` = ~lane bits.
  - All three are registered.
- `alive_led` = bit `ALIVE_BIT` of a free-running (ALIVE_BIT+1)-bit counter. It wraps silently.
- Counters saturate at all-ones. If `cnt_clr` and an increment occur in the same cycle, `cnt_clr` wins and the result is 0.
- Reset values:
  - State DOWN; `ltssm_q` = 0; `link_up` = 0.
  - `l0_led`, `comp_led` and `lane_led` = all 1 (dark).
  - `alive_led` = 0; `ltssm_change` = 0; both counters = 0.
- Reset asserted mid-operation forces every reset value at the next edge, including mid-TRAIN and mid-RECOV.

## Timing
- Let edge k be the first edge at which `test_out_icm` shows L0.
  - `ltssm_q` and `ltssm_change` update after edge k.
  - The LEDs update after edge k+1.
  - If L0 is held, `link_up` rises after edge k+DEBOUNCE_CYC+1.
- Link drop: `link_up` falls 2 edges after a non-L0, non-Recovery state is sampled. The counter increments on the same edge.
- `ltssm_change` is high for exactly one cycle per change of `ltssm_q`. It is never high in the cycle after reset release.

## Configuration
- `PCIE_LINK_MON_STATS_EN` defined: `ltssm_change`, `link_down_cnt`, `recovery_cnt` and `cnt_clr` are functional.
- Not defined: those three outputs are tied to 0, `cnt_clr` is ignored, and no counter flops are synthesised. The FSM, `link_up` and the LEDs are unchanged.

## Structure
- Package `pcie_link_mon_pkg` holds:
  - the LTSSM encoding constants (L0, POLL_COMPL, REC_LOCK, REC_CFG, REC_IDLE);
  - the FSM state enum `link_st_t`;
  - the lane-active bit offset (25).
- Sub-module `pcie_sat_counter`: parameter W, with inputs inc and clr and a count output. It is instantiated twice under the macro.

## Test plan
- Reset: hold `rst` high with `test_out_icm` = L0 → all reset values hold, and `link_up` = 0 throughout.
- Link-up debounce (DEBOUNCE_CYC = 8): drive L0 from edge k → `link_up` = 1 after edge k+9. `l0_led` = 0 after edge k+1.
- Glitch: drive L0 for 5 cycles, one cycle of 5'b00010, then L0 → FSM returns to DOWN. `link_down_cnt` stays 0, and `link_up` rises 9 edges after L0 returns.
- Recovery: from UP, drive 5'b01100 for 3 cycles then L0 → `link_up` stays 1 and `recovery_cnt` = 1. Then drive 5'b00000 → `link_up` falls 2 edges later and `link_down_cnt` = 1.
- Saturation and clear (CNT_W = 2): cause 5 link drops → `link_down_cnt` = 3. Assert `cnt_clr` in the same cycle as a 6th drop → result 0.
- Lanes and compliance (NUM_LANES = 4): set bits [28:25] = 4'b0101 and LTSSM = 5'b00011 → `lane_led` = 4'b1010 and `comp_led` = 0, two edges later.
